morse_char_keyer: RTL and testbench

- Sequential Morse transmitter.
- Accepts one ASCII character per valid/ready handshake, looks the character up internally and drives a timed on/off key output (LED/buzzer).
- Generalises the combinational ASCII-to-Morse lookup with:
  - parametrised unit timing and gap lengths;
  - case folding and word spaces;
  - an optional punctuation set.
- Sits between the UART/character source and the blinker output pin.

---
 rtl/morse_char_keyer.sv | 219 +++++++++++++++++++++
 tb/tb_morse_char_keyer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_keyer.sv
// morse_char_keyer
//   Sequential Morse transmitter. Accepts one ASCII character per valid/ready
//   handshake, looks it up in an internal code table and drives a timed
//   on/off key output for an LED or buzzer.
//
//   Optional feature: define MORSE_PUNCT_EN to add . , ? / = to the table.
//   Without it those characters are unmapped and raise o_Err.
//
// Ports:
//   i_Clk    - system clock, all logic on the rising edge
//   i_Rst_L  - asynchronous active-low reset
//   i_ASCII  - character to send, sampled on accept
//   i_Valid  - character present on i_ASCII
//   o_Ready  - keyer can accept a character this cycle (IDLE only)
//   o_Key    - key/LED drive, 1 = tone/light on
//   o_Busy   - high whenever not in IDLE
//   o_Err    - one-cycle pulse: accepted character had no Morse code
module morse_char_keyer #(
    parameter int unsigned CLKS_PER_UNIT    = 2500000,
    parameter int unsigned DASH_UNITS       = 3,
    parameter int unsigned ELEM_GAP_UNITS   = 1,
    parameter int unsigned CHAR_GAP_UNITS   = 3,
    parameter int unsigned WORD_EXTRA_UNITS = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [7:0] i_ASCII,
    input  logic       i_Valid,
    output logic       o_Ready,
    output logic       o_Key,
    output logic       o_Busy,
    output logic       o_Err
);

    localparam int unsigned MAX_UNITS =
        (DASH_UNITS > CHAR_GAP_UNITS) ?
            ((DASH_UNITS > WORD_EXTRA_UNITS) ? DASH_UNITS : WORD_EXTRA_UNITS) :
            ((CHAR_GAP_UNITS > WORD_EXTRA_UNITS) ? CHAR_GAP_UNITS : WORD_EXTRA_UNITS);
    localparam int unsigned CYC_W  = $clog2(CLKS_PER_UNIT);
    localparam int unsigned UNIT_W = $clog2(MAX_UNITS + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(CLKS_PER_UNIT - 1);
    localparam logic [UNIT_W-1:0] DOT_LAST   = '0;
    localparam logic [UNIT_W-1:0] DASH_LAST  = UNIT_W'(DASH_UNITS - 1);
    localparam logic [UNIT_W-1:0] ELEM_LAST  = UNIT_W'(ELEM_GAP_UNITS - 1);
    localparam logic [UNIT_W-1:0] CHAR_LAST  = UNIT_W'(CHAR_GAP_UNITS - 1);
    localparam logic [UNIT_W-1:0] WORD_LAST  = UNIT_W'(WORD_EXTRA_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    state_t             state;
    logic [CYC_W-1:0]   cyc;
    logic [UNIT_W-1:0]  units;
    logic [5:0]         pat;
    logic [2:0]         len;
    logic [2:0]         idx;

    logic [7:0]         folded;
    logic [5:0]         lk_pat;
    logic [2:0]         lk_len;
    logic               cur_dash;
    logic               last_elem;
    logic [UNIT_W-1:0]  unit_last;
    logic               span_done;

    // Code lookup on the raw input; a zero length means "no Morse code".
    always_comb begin
        folded = i_ASCII;
        if (i_ASCII >= 8'h61 && i_ASCII <= 8'h7A) begin
            folded = i_ASCII - 8'h20;
        end
        lk_pat = '0;
        lk_len = '0;
        case (folded)
            8'h41: {lk_len, lk_pat} = {3'd2, 6'b010000}; // A
            8'h42: {lk_len, lk_pat} = {3'd4, 6'b100000}; // B
            8'h43: {lk_len, lk_pat} = {3'd4, 6'b101000}; // C
            8'h44: {lk_len, lk_pat} = {3'd3, 6'b100000}; // D
            8'h45: {lk_len, lk_pat} = {3'd1, 6'b000000}; // E
            8'h46: {lk_len, lk_pat} = {3'd4, 6'b001000}; // F
            8'h47: {lk_len, lk_pat} = {3'd3, 6'b110000}; // G
            8'h48: {lk_len, lk_pat} = {3'd4, 6'b000000}; // H
            8'h49: {lk_len, lk_pat} = {3'd2, 6'b000000}; // I
            8'h4A: {lk_len, lk_pat} = {3'd4, 6'b011100}; // J
            8'h4B: {lk_len, lk_pat} = {3'd3, 6'b101000}; // K
            8'h4C: {lk_len, lk_pat} = {3'd4, 6'b010000}; // L
            8'h4D: {lk_len, lk_pat} = {3'd2, 6'b110000}; // M
            8'h4E: {lk_len, lk_pat} = {3'd2, 6'b100000}; // N
            8'h4F: {lk_len, lk_pat} = {3'd3, 6'b111000}; // O
            8'h50: {lk_len, lk_pat} = {3'd4, 6'b011000}; // P
            8'h51: {lk_len, lk_pat} = {3'd4, 6'b110100}; // Q
            8'h52: {lk_len, lk_pat} = {3'd3, 6'b010000}; // R
            8'h53: {lk_len, lk_pat} = {3'd3, 6'b000000}; // S
            8'h54: {lk_len, lk_pat} = {3'd1, 6'b100000}; // T
            8'h55: {lk_len, lk_pat} = {3'd3, 6'b001000}; // U
            8'h56: {lk_len, lk_pat} = {3'd4, 6'b000100}; // V
            8'h57: {lk_len, lk_pat} = {3'd3, 6'b011000}; // W
            8'h58: {lk_len, lk_pat} = {3'd4, 6'b100100}; // X
            8'h59: {lk_len, lk_pat} = {3'd4, 6'b101100}; // Y
            8'h5A: {lk_len, lk_pat} = {3'd4, 6'b110000}; // Z
            8'h30: {lk_len, lk_pat} = {3'd5, 6'b111110}; // 0
            8'h31: {lk_len, lk_pat} = {3'd5, 6'b011110}; // 1
            8'h32: {lk_len, lk_pat} = {3'd5, 6'b001110}; // 2
            8'h33: {lk_len, lk_pat} = {3'd5, 6'b000110}; // 3
            8'h34: {lk_len, lk_pat} = {3'd5, 6'b000010}; // 4
            8'h35: {lk_len, lk_pat} = {3'd5, 6'b000000}; // 5
            8'h36: {lk_len, lk_pat} = {3'd5, 6'b100000}; // 6
            8'h37: {lk_len, lk_pat} = {3'd5, 6'b110000}; // 7
            8'h38: {lk_len, lk_pat} = {3'd5, 6'b111000}; // 8
            8'h39: {lk_len, lk_pat} = {3'd5, 6'b111100}; // 9
`ifdef MORSE_PUNCT_EN
            8'h2E: {lk_len, lk_pat} = {3'd6, 6'b010101}; // .
            8'h2C: {lk_len, lk_pat} = {3'd6, 6'b110011}; // ,
            8'h3F: {lk_len, lk_pat} = {3'd6, 6'b001100}; // ?
            8'h2F: {lk_len, lk_pat} = {3'd5, 6'b100100}; // /
            8'h3D: {lk_len, lk_pat} = {3'd5, 6'b100010}; // =
`endif
            default: {lk_len, lk_pat} = '0;
        endcase
    end

    // Current element is read MSB-first from the left-aligned pattern.
    always_comb begin
        cur_dash  = pat[3'd5 - idx];
        last_elem = (idx == len - 3'd1);
        unit_last = DOT_LAST;
        case (state)
            MARK:     unit_last = cur_dash ? DASH_LAST : DOT_LAST;
            ELEM_GAP: unit_last = ELEM_LAST;
            CHAR_GAP: unit_last = CHAR_LAST;
            WORD_GAP: unit_last = WORD_LAST;
            default:  unit_last = DOT_LAST;
        endcase
        span_done = (cyc == CYC_LAST) && (units == unit_last);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state   <= IDLE;
            cyc     <= '0;
            units   <= '0;
            pat     <= '0;
            len     <= '0;
            idx     <= '0;
            o_Ready <= 1'b1;
            o_Key   <= 1'b0;
            o_Busy  <= 1'b0;
            o_Err   <= 1'b0;
        end else begin
            o_Err <= 1'b0;
            if (state != IDLE) begin
                if (span_done) begin
                    cyc   <= '0;
                    units <= '0;
                end else if (cyc == CYC_LAST) begin
                    cyc   <= '0;
                    units <= units + 1'b1;
                end else begin
                    cyc <= cyc + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        if (lk_len != 3'd0) begin
                            pat     <= lk_pat;
                            len     <= lk_len;
                            idx     <= '0;
                            state   <= MARK;
                            o_Key   <= 1'b1;
                            o_Ready <= 1'b0;
                            o_Busy  <= 1'b1;
                        end else if (i_ASCII == 8'h20) begin
                            state   <= WORD_GAP;
                            o_Ready <= 1'b0;
                            o_Busy  <= 1'b1;
                        end else begin
                            // Unmapped: stay ready so the source can retry at once.
                            o_Err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (span_done) begin
                        o_Key <= 1'b0;
                        state <= last_elem ? CHAR_GAP : ELEM_GAP;
                    end
                end
                ELEM_GAP: begin
                    if (span_done) begin
                        idx   <= idx + 3'd1;
                        o_Key <= 1'b1;
                        state <= MARK;
                    end
                end
                CHAR_GAP, WORD_GAP: begin
                    if (span_done) begin
                        state   <= IDLE;
                        o_Ready <= 1'b1;
                        o_Busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_Key   <= 1'b0;
                    o_Ready <= 1'b1;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_char_keyer.sv
// Testbench for morse_char_keyer with CLKS_PER_UNIT = 4, other parameters default.
module tb_morse_char_keyer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ascii;
    logic       valid;
    logic       ready, key, busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    morse_char_keyer #(
        .CLKS_PER_UNIT(4)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .i_ASCII (ascii),
        .i_Valid (valid),
        .o_Ready (ready),
        .o_Key   (key),
        .o_Busy  (busy),
        .o_Err   (err)
    );

    typedef struct {
        logic [7:0] ch;
        int         exp_err;
        int         exp_busy;
        int         exp_on;
        int         exp_marks;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sends one character from IDLE and records the key waveform, one sample
    // per cycle starting half a cycle after the accept edge.
    task automatic send_measure(input logic [7:0] ch, output int busy_n, output int on_n,
                                output int marks_n, output int err_first,
                                output logic [127:0] trace);
        logic prev;
        @(negedge clk);
        ascii = ch;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        ascii = 8'h45;
        err_first = int'(err);
        busy_n = 0;
        on_n = 0;
        marks_n = 0;
        prev = 1'b0;
        trace = '0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) break;
            if (key) begin
                on_n++;
                if (i < 128) trace[i] = 1'b1;
                if (!prev) marks_n++;
            end
            prev = key;
            busy_n++;
            @(negedge clk);
        end
        if (busy) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    vec_t vecs[15];
    int bn, on, mk, ef;
    logic [127:0] tr, tr_a;
    logic [7:0] seq[3];
    int n, s, r_on1, r_off, r_on2;
    logic rdy;

    initial begin
        vecs[0]  = '{8'h65, 0, 16, 4, 1};    // e
        vecs[1]  = '{8'h41, 0, 32, 16, 2};   // A
        vecs[2]  = '{8'h61, 0, 32, 16, 2};   // a
        vecs[3]  = '{8'h74, 0, 24, 12, 1};   // t
        vecs[4]  = '{8'h30, 0, 88, 60, 5};   // 0
        vecs[5]  = '{8'h35, 0, 48, 20, 5};   // 5
        vecs[6]  = '{8'h5A, 0, 56, 32, 4};   // Z
        vecs[7]  = '{8'h71, 0, 64, 40, 4};   // q
        vecs[8]  = '{8'h20, 0, 16, 0, 0};    // space
        vecs[9]  = '{8'h7E, 1, 0, 0, 0};     // ~
        vecs[10] = '{8'h40, 1, 0, 0, 0};     // @ just below 'A'
        vecs[11] = '{8'h60, 1, 0, 0, 0};     // ` just below 'a'
        vecs[12] = '{8'h7B, 1, 0, 0, 0};     // { just above 'z'
`ifdef MORSE_PUNCT_EN
        vecs[13] = '{8'h2E, 0, 80, 48, 6};   // .
        vecs[14] = '{8'h2F, 0, 64, 36, 5};   // /
`else
        vecs[13] = '{8'h2E, 1, 0, 0, 0};
        vecs[14] = '{8'h2F, 1, 0, 0, 0};
`endif

        rst_n = 1'b0;
        valid = 1'b0;
        ascii = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_key",   32'(key),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_err",   32'(err),   32'd0);

        for (int v = 0; v < 15; v++) begin
            send_measure(vecs[v].ch, bn, on, mk, ef, tr);
            check($sformatf("err_%02h", vecs[v].ch),   32'(ef), 32'(vecs[v].exp_err));
            check($sformatf("busy_%02h", vecs[v].ch),  32'(bn), 32'(vecs[v].exp_busy));
            check($sformatf("on_%02h", vecs[v].ch),    32'(on), 32'(vecs[v].exp_on));
            check($sformatf("marks_%02h", vecs[v].ch), 32'(mk), 32'(vecs[v].exp_marks));
            check($sformatf("ready_%02h", vecs[v].ch), 32'(ready), 32'd1);
            @(negedge clk);
            check($sformatf("errlow_%02h", vecs[v].ch), 32'(err), 32'd0);
        end

        // Exact waveforms: 'e' is 4 on / 12 off; 'A' and 'a' are 4 on, 4 off, 12 on, 12 off.
        send_measure(8'h65, bn, on, mk, ef, tr);
        check("e_wave", tr[31:0], 32'h0000_000F);
        check("e_ready", 32'(ready), 32'd1);
        send_measure(8'h41, bn, on, mk, ef, tr_a);
        check("A_wave", tr_a[31:0], 32'h000F_FF0F);
        send_measure(8'h61, bn, on, mk, ef, tr);
        check("a_wave", tr[63:0], tr_a[63:0]);

        // t, space, t with i_Valid held: low time is char gap 12 + word gap 16
        // plus one IDLE handshake cycle before each following accept.
        seq[0] = 8'h74; seq[1] = 8'h20; seq[2] = 8'h74;
        @(negedge clk);
        ascii = seq[0];
        valid = 1'b1;
        n = 0;
        s = 0;
        tr = '0;
        rdy = ready;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy && valid) begin
                n++;
                if (n == 3) valid = 1'b0;
                else ascii = seq[n];
            end
            if (s < 128) tr[s] = key;
            s++;
            rdy = ready;
            if (n == 3 && !busy) break;
        end
        check("tst_done", 32'(n), 32'd3);
        r_on1 = 0; r_off = 0; r_on2 = 0;
        for (int i = 0; i < 128; i++) begin
            if (r_off == 0 && tr[i]) r_on1++;
            else if (r_on2 == 0 && !tr[i]) r_off++;
            else if (tr[i]) r_on2++;
        end
        check("tst_on1", 32'(r_on1), 32'd12);
        check("tst_off", 32'(r_off), 32'd30);
        check("tst_on2", 32'(r_on2), 32'd12);

        // Back-to-back unmapped characters: two err cycles, ready stays high.
        @(negedge clk);
        ascii = 8'h7E;
        valid = 1'b1;
        @(negedge clk);
        check("bb_err1", 32'(err), 32'd1);
        check("bb_rdy1", 32'(ready), 32'd1);
        check("bb_key1", 32'(key), 32'd0);
`ifdef MORSE_PUNCT_EN
        ascii = 8'h7E;
`else
        ascii = 8'h2E;
`endif
        @(negedge clk);
        valid = 1'b0;
        check("bb_err2", 32'(err), 32'd1);
        check("bb_rdy2", 32'(ready), 32'd1);
        check("bb_key2", 32'(key), 32'd0);
        @(negedge clk);
        check("bb_err3", 32'(err), 32'd0);

        // '0' interrupted by asynchronous reset mid-second-dash (samples 16..27).
        @(negedge clk);
        ascii = 8'h30;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_key", 32'(key), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_key",   32'(key),   32'd0);
        check("arst_busy",  32'(busy),  32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready), 32'd1);
        send_measure(8'h65, bn, on, mk, ef, tr);
        check("post_rst_e_busy", 32'(bn), 32'd16);
        check("post_rst_e_wave", tr[31:0], 32'h0000_000F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
